// File: rtl/sram_ctrl_if.sv
// Request/response bus between a requester and sram_ctrl.
// master = requester side, slave = controller side.
interface sram_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_ctrl.sv
// Single-request sequencer for an asynchronous SRAM macro; all SRAM strobes registered.
// Optional write read-back verify: define SRAM_CTRL_WRVERIFY_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | cs low, req_ready high, waiting for a request
// W_SETUP  | cs high, addr/din settling before the write pulse
// W_PULSE  | wr high for WR_PULSE cycles
// W_HOLD   | wr low, addr/din held; responds (or starts read-back)
// R_SETUP  | cs high, rd still high
// R_STROBE | rd low for RD_WAIT cycles; dout captured on the last edge
// R_DONE   | rd high, response pulse
module sram_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int MAX_WAIT = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_STROBE, R_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
    logic              err_q;
`endif

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            sram_cs     <= 1'b0;
            sram_wr     <= 1'b0;
            sram_rd     <= 1'b1;
            sram_addr   <= '0;
            sram_din    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef SRAM_CTRL_WRVERIFY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        // sram_addr/sram_din double as the request register
                        sram_addr <= bus.req_addr;
                        sram_din  <= bus.req_wdata;
                        we_q      <= bus.req_we;
                        sram_cs   <= 1'b1;
                        cnt       <= '0;
                        state     <= bus.req_we ? W_SETUP : R_SETUP;
                    end
                end
                W_SETUP: begin
                    sram_wr <= 1'b1;
                    cnt     <= WR_LOAD;
                    state   <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt == '0) begin
                        sram_wr <= 1'b0;
                        state   <= W_HOLD;
`ifndef SRAM_CTRL_WRVERIFY_EN
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                W_HOLD: begin
                    cnt <= '0;
`ifdef SRAM_CTRL_WRVERIFY_EN
                    state <= R_SETUP;
`else
                    rsp_valid_q <= 1'b0;
                    sram_cs     <= 1'b0;
                    state       <= IDLE;
`endif
                end
                R_SETUP: begin
                    sram_rd <= 1'b0;
                    cnt     <= RD_LOAD;
                    state   <= R_STROBE;
                end
                R_STROBE: begin
                    if (cnt == '0) begin
                        sram_rd     <= 1'b1;
                        rsp_rdata_q <= sram_dout;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= we_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
                        err_q       <= we_q && (sram_dout != sram_din);
`endif
                        state       <= R_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                R_DONE: begin
                    rsp_valid_q <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
                    err_q       <= 1'b0;
`endif
                    sram_cs     <= 1'b0;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: begin
                    sram_cs <= 1'b0;
                    sram_wr <= 1'b0;
                    sram_rd <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
